// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - pixel RAM arbiter: display > fill > host, with host request queue
// Optional counters stat_disp_cnt/stat_host_stall enabled by VRAM_ARB_STATS_EN.
module vram_arbiter #(
  parameter int AW         = 17,
  parameter int DW         = 12,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          host_valid,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ready,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_base,
  input  logic [AW-1:0] fill_len,
  input  logic [DW-1:0] fill_data,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_disp_cnt,
  output logic [15:0]   stat_host_stall
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + AW + DW;
  localparam logic [AW-1:0] ADDR_ONE = 1;
  localparam logic [PW:0]   PTR_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cur_q, cur_d, rem_q, rem_d;
  logic [DW-1:0] fdata_q, fdata_d;
  logic [EW-1:0] fifo_q [FIFO_DEPTH];
  logic [EW-1:0] fifo_d [FIFO_DEPTH];
  logic [PW:0]   rptr_q, rptr_d, wptr_q, wptr_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  // Each tag is {valid, is_disp}; stage 0 is aligned with the mem_* registers.
  logic [1:0]    tag_q [MEM_LAT+1];
  logic [1:0]    tag_d [MEM_LAT+1];
  logic          fifo_empty, fifo_full, push, pop;
  logic [EW-1:0] head;
  logic [1:0]    tag_out;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]   disp_cnt_q, disp_cnt_d, stall_cnt_q, stall_cnt_d;
`endif

  assign fifo_empty = (rptr_q == wptr_q);
  assign fifo_full  = (rptr_q[PW] != wptr_q[PW]) && (rptr_q[PW-1:0] == wptr_q[PW-1:0]);
  assign head       = fifo_q[rptr_q[PW-1:0]];
  assign push       = host_valid && !fifo_full;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rem_d       = rem_q;
    fdata_d     = fdata_q;
    fifo_d      = fifo_q;
    rptr_d      = rptr_q;
    wptr_d      = wptr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    pop         = 1'b0;
    tag_d[0]    = 2'b00;
    for (int i = 1; i <= MEM_LAT; i++) tag_d[i] = tag_q[i-1];

    if (disp_req) begin
      mem_en_d   = 1'b1;
      mem_addr_d = disp_addr;
      tag_d[0]   = 2'b11;
    end else if (state_q == S_FILL) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = cur_q;
      mem_wdata_d = fdata_q;
      cur_d       = cur_q + ADDR_ONE;
      rem_d       = rem_q - ADDR_ONE;
      if (rem_q == ADDR_ONE) state_d = S_DONE;
    end else if ((state_q == S_IDLE) && !fifo_empty) begin
      pop         = 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = head[EW-1];
      mem_addr_d  = head[AW+DW-1:DW];
      mem_wdata_d = head[DW-1:0];
      tag_d[0]    = {~head[EW-1], 1'b0};
    end

    case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          if (fill_len != '0) begin
            state_d = S_FILL;
            cur_d   = fill_base;
            rem_d   = fill_len;
            fdata_d = fill_data;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase

    if (pop) rptr_d = rptr_q + PTR_ONE;
    if (push) begin
      fifo_d[wptr_q[PW-1:0]] = {host_we, host_addr, host_wdata};
      wptr_d                 = wptr_q + PTR_ONE;
    end

`ifdef VRAM_ARB_STATS_EN
    disp_cnt_d  = disp_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (disp_req && (disp_cnt_q != 16'hFFFF)) disp_cnt_d = disp_cnt_q + 16'd1;
    if (!fifo_empty && !pop && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      rem_q       <= '0;
      fdata_q     <= '0;
      rptr_q      <= '0;
      wptr_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i <= MEM_LAT; i++) tag_q[i] <= 2'b00;
`ifdef VRAM_ARB_STATS_EN
      disp_cnt_q  <= '0;
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      fdata_q     <= fdata_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      for (int i = 0; i <= MEM_LAT; i++) tag_q[i] <= tag_d[i];
`ifdef VRAM_ARB_STATS_EN
      disp_cnt_q  <= disp_cnt_d;
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  // Queue storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign tag_out     = tag_q[MEM_LAT];
  assign disp_rvalid = !reset && tag_out[1] && tag_out[0];
  assign host_rvalid = !reset && tag_out[1] && !tag_out[0];
  assign disp_rdata  = disp_rvalid ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;
  assign host_ready  = !reset && !fifo_full;
  assign fill_busy   = !reset && (state_q == S_FILL);
  assign fill_done   = !reset && (state_q == S_DONE);
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
`ifdef VRAM_ARB_STATS_EN
  assign stat_disp_cnt   = disp_cnt_q;
  assign stat_host_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - randomized and directed bench for vram_arbiter with a queue-based model
module tb_vram_arbiter;

  localparam int AW = 17;
  localparam int DW = 12;
  localparam int MEM_LAT = 2;
  localparam int FIFO_DEPTH = 4;

  logic          clk, reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          host_valid, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ready, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          fill_start;
  logic [AW-1:0] fill_base, fill_len;
  logic [DW-1:0] fill_data;
  logic          fill_busy, fill_done;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]   stat_disp_cnt, stat_host_stall;
`endif

  vram_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_data(fill_data),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef VRAM_ARB_STATS_EN
    , .stat_disp_cnt(stat_disp_cnt), .stat_host_stall(stat_host_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(logic [AW-1:0] a);
    return a[11:0] ^ 12'h5A5;
  endfunction

  // RAM macro: unwritten words read back a fixed address pattern.
  logic [DW-1:0] ram    [1<<AW];
  bit            ram_wr [1<<AW];
  logic [DW-1:0] rd_pipe [MEM_LAT];

  function automatic logic [DW-1:0] ram_rd(logic [AW-1:0] a);
    return ram_wr[a] ? ram[a] : pat(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? ram_rd(mem_addr) : '0;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} hreq_t;
  typedef struct {int due; bit disp; logic [DW-1:0] data;} rd_t;

  hreq_t         hq[$];
  rd_t           sched[$];
  logic [DW-1:0] shadow [1<<AW];
  int            fill_left;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_val;
  bit            done_pend;
  int            cyc;
  bit            exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;

  int checks, passed, fails;
  int done_seen, host_rv_seen;
  logic [DW-1:0] last_hrdata;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Serial view: at most one RAM op per cycle, chosen display > fill > host queue.
  task automatic model_edge();
    bit    idle, was_done, push;
    hreq_t h;
    exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    if (reset) begin
      hq.delete();
      sched.delete();
      fill_left = 0;
      done_pend = 1'b0;
    end else begin
      idle     = (fill_left == 0) && !done_pend;
      was_done = done_pend;
      push     = host_valid && (hq.size() < FIFO_DEPTH);
      if (disp_req) begin
        exp_en = 1'b1; exp_addr = disp_addr;
        sched.push_back(rd_t'{cyc + 1 + MEM_LAT, 1'b1, shadow[disp_addr]});
      end else if (fill_left > 0) begin
        exp_en = 1'b1; exp_we = 1'b1; exp_addr = fill_addr; exp_wdata = fill_val;
        shadow[fill_addr] = fill_val;
        fill_addr = fill_addr + 17'd1;
        fill_left--;
        if (fill_left == 0) done_pend = 1'b1;
      end else if (idle && hq.size() > 0) begin
        h = hq.pop_front();
        exp_en = 1'b1; exp_we = h.we; exp_addr = h.addr;
        if (h.we) begin
          exp_wdata = h.wdata;
          shadow[h.addr] = h.wdata;
        end else begin
          sched.push_back(rd_t'{cyc + 1 + MEM_LAT, 1'b0, shadow[h.addr]});
        end
      end
      if (was_done) done_pend = 1'b0;
      if (idle && fill_start) begin
        if (fill_len != '0) begin
          fill_left = int'(fill_len); fill_addr = fill_base; fill_val = fill_data;
        end else begin
          done_pend = 1'b1;
        end
      end
      if (push) hq.push_back(hreq_t'{host_we, host_addr, host_wdata});
    end
    cyc++;
  endtask

  task automatic check_outputs();
    bit            exp_dv, exp_hv;
    logic [DW-1:0] exp_d;
    rd_t           r;
    exp_dv = 1'b0; exp_hv = 1'b0; exp_d = '0;
    if (sched.size() > 0 && sched[0].due == cyc) begin
      r = sched.pop_front();
      exp_dv = r.disp; exp_hv = !r.disp; exp_d = r.data;
    end
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    if (exp_en) begin
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    end
    chk("disp_rvalid", 32'(disp_rvalid), 32'(exp_dv));
    chk("host_rvalid", 32'(host_rvalid), 32'(exp_hv));
    if (exp_dv) chk("disp_rdata", 32'(disp_rdata), 32'(exp_d));
    if (exp_hv) chk("host_rdata", 32'(host_rdata), 32'(exp_d));
    chk("host_ready", 32'(host_ready), 32'(!reset && hq.size() < FIFO_DEPTH));
    chk("fill_busy", 32'(fill_busy), 32'(!reset && fill_left > 0));
    chk("fill_done", 32'(fill_done), 32'(!reset && done_pend));
    if (fill_done) done_seen++;
    if (host_rvalid) begin
      host_rv_seen++;
      last_hrdata = host_rdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic quiet();
    disp_req = 0; disp_addr = '0; host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    fill_start = 0; fill_base = '0; fill_len = '0; fill_data = '0;
  endtask

  int d0, hv0;

  initial begin
    checks = 0; passed = 0; fails = 0; cyc = 0; done_seen = 0; host_rv_seen = 0;
    last_hrdata = '0; fill_left = 0; done_pend = 1'b0; fill_addr = '0; fill_val = '0;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = pat(17'(i));
    quiet();
    reset = 1;
    repeat (3) tick();
    reset = 0;
    #1;
    chk("ready_after_reset", 32'(host_ready), 32'd1);

    // Display every 4th cycle against back-to-back host writes.
    for (int i = 0; i < 40; i++) begin
      disp_req = (i % 4 == 0); disp_addr = 17'($urandom);
      host_valid = 1; host_we = 1; host_addr = 17'($urandom_range(0, 63)); host_wdata = 12'($urandom);
      tick();
    end
    quiet();
    repeat (10) tick();

    // Write then read the same address.
    host_valid = 1; host_we = 1; host_addr = 17'h00010; host_wdata = 12'hABC;
    tick();
    host_we = 0; host_wdata = '0;
    tick();
    quiet();
    repeat (6) tick();
    chk("raw_rdata", 32'(last_hrdata), 32'hABC);

    // Fill across the address wrap with alternating display requests.
    fill_start = 1; fill_base = 17'h1FFFE; fill_len = 17'd4; fill_data = 12'hF00;
    tick();
    quiet();
    d0 = done_seen;
    for (int i = 0; i < 12; i++) begin
      disp_req = (i % 2 == 0); disp_addr = 17'(i);
      tick();
    end
    quiet();
    tick();
    chk("fill_done_pulses", 32'(done_seen - d0), 32'd1);
    chk("fill_ram_1ffff", 32'(ram_rd(17'h1FFFF)), 32'hF00);
    chk("fill_ram_00001", 32'(ram_rd(17'h00001)), 32'hF00);
    chk("fill_ram_00002", 32'(ram_rd(17'h00002)), 32'(pat(17'h00002)));

    // Queue fills up under continuous display traffic, then drains.
    disp_req = 1; host_valid = 1; host_we = 1;
    for (int i = 0; i < 6; i++) begin
      disp_addr = 17'(i); host_addr = 17'h100 + 17'(i); host_wdata = 12'h300 + 12'(i);
      tick();
    end
    quiet();
    repeat (8) tick();

    // Reset during a fill while a host read is still in the RAM pipe.
    host_valid = 1; host_we = 0; host_addr = 17'h00020;
    tick();
    quiet();
    fill_start = 1; fill_base = 17'h300; fill_len = 17'd50; fill_data = 12'h123;
    tick();
    quiet();
    tick();
    hv0 = host_rv_seen;
    reset = 1;
    tick();
    reset = 0;
    repeat (6) tick();
    chk("reset_kills_rvalid", 32'(host_rv_seen - hv0), 32'd0);

    // Randomized traffic on a small address window to exercise ordering hazards.
    for (int i = 0; i < 400; i++) begin
      disp_req = ($urandom_range(0, 2) == 0); disp_addr = 17'($urandom_range(0, 15));
      host_valid = 1'($urandom_range(0, 1)); host_we = 1'($urandom_range(0, 1));
      host_addr = 17'($urandom_range(0, 15)); host_wdata = 12'($urandom);
      fill_start = ($urandom_range(0, 29) == 0);
      fill_base = ($urandom_range(0, 1) == 1) ? 17'h1FFFC : 17'($urandom_range(0, 15));
      fill_len = 17'($urandom_range(0, 6)); fill_data = 12'($urandom);
      tick();
    end
    quiet();
    repeat (20) tick();

`ifdef VRAM_ARB_STATS_EN
    reset = 1;
    repeat (2) tick();
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      disp_req = 1; disp_addr = 17'(i);
      host_valid = (i == 6); host_we = 1; host_addr = 17'h40; host_wdata = 12'h777;
      tick();
    end
    quiet();
    repeat (2) tick();
    chk("stat_disp_cnt", 32'(stat_disp_cnt), 32'd10);
    chk("stat_host_stall", 32'(stat_host_stall), 32'd3);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
